// File: rtl/priority_encoder_8to3.sv
// Highest-priority encoder: reports the index of the most-significant set
// bit of a request vector, with a valid flag and a one-hot grant.
// There is no handshake. A new request vector is accepted every cycle.
// With REG_OUT=1 the outputs are registered, giving one cycle of latency.
// With REG_OUT=0 the outputs follow `in` combinationally.
module priority_encoder_8to3 #(
  parameter int WIDTH   = 8,
  parameter int OUT_W   = $clog2(WIDTH),
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic [WIDTH-1:0] grant
);

  logic [OUT_W-1:0] out_d;
  logic             valid_d;
  logic [WIDTH-1:0] grant_d;

  // Scan from LSB to MSB so the last (highest) set bit wins.
  always_comb begin
    out_d   = '0;
    valid_d = 1'b0;
    grant_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        out_d      = OUT_W'(i);
        valid_d    = 1'b1;
        grant_d    = '0;
        grant_d[i] = 1'b1;
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [OUT_W-1:0] out_q;
      logic             valid_q;
      logic [WIDTH-1:0] grant_q;

      // Output stage: clears asynchronously and loads the encoding each edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q   <= '0;
          valid_q <= 1'b0;
          grant_q <= '0;
        end else begin
          out_q   <= out_d;
          valid_q <= valid_d;
          grant_q <= grant_d;
        end
      end

      assign out   = out_q;
      assign valid = valid_q;
      assign grant = grant_q;
    end else begin : g_comb
      assign out   = out_d;
      assign valid = valid_d;
      assign grant = grant_d;
    end
  endgenerate

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Bench for priority_encoder_8to3. It drives a registered instance and a
// combinational instance from the same request vector, and compares both
// against an arithmetic reference model.
module tb_priority_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_r;
  logic [2:0] r_out;
  logic       r_valid;
  logic [7:0] r_grant;
  logic [2:0] c_out;
  logic       c_valid;
  logic [7:0] c_grant;

  int checks   = 0;
  int failures = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  priority_encoder_8to3 #(.WIDTH(8), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .in(in_r),
    .out(r_out), .valid(r_valid), .grant(r_grant)
  );

  priority_encoder_8to3 #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .in(in_r),
    .out(c_out), .valid(c_valid), .grant(c_grant)
  );

  // Reference model: floor(log2(v)) found by repeated halving.
  function automatic logic [2:0] ref_out(input logic [7:0] v);
    int x = int'(v);
    int n = 0;
    while (x > 1) begin
      x = x / 2;
      n++;
    end
    return 3'(n);
  endfunction

  function automatic logic ref_valid(input logic [7:0] v);
    return v != 8'd0;
  endfunction

  function automatic logic [7:0] ref_grant(input logic [7:0] v);
    return (v != 8'd0) ? 8'(1 << ref_out(v)) : 8'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [7:0] v);
    check({tag, ".reg_out"},   32'(r_out),   32'(ref_out(v)));
    check({tag, ".reg_valid"}, 32'(r_valid), 32'(ref_valid(v)));
    check({tag, ".reg_grant"}, 32'(r_grant), 32'(ref_grant(v)));
  endtask

  task automatic check_comb(input string tag, input logic [7:0] v);
    check({tag, ".comb_out"},   32'(c_out),   32'(ref_out(v)));
    check({tag, ".comb_valid"}, 32'(c_valid), 32'(ref_valid(v)));
    check({tag, ".comb_grant"}, 32'(c_grant), 32'(ref_grant(v)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"},   32'(r_out),   32'd0);
    check({tag, ".valid"}, 32'(r_valid), 32'd0);
    check({tag, ".grant"}, 32'(r_grant), 32'd0);
  endtask

  // Driver: apply v on the falling edge, check the combinational copy,
  // then check the registered copy just after the next rising edge.
  task automatic step(input string tag, input logic [7:0] v);
    @(negedge clk);
    in_r = v;
    #1;
    check_comb(tag, v);
    @(posedge clk);
    #1;
    check_reg(tag, v);
  endtask

  initial begin
    rst_n = 1'b0;
    in_r  = 8'h80;
    #2;
    check_zero("por");
    @(posedge clk);
    #1;
    check_zero("por_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Walking one
    for (int i = 0; i < 8; i++) step("walk", 8'(1 << i));

    // Multi-bit and boundary patterns
    step("multi_18", 8'b0001_1000);
    check("multi_18.out_lit", 32'(r_out), 32'd4);
    check("multi_18.grant_lit", 32'(r_grant), 32'h10);
    step("multi_60", 8'b0110_0000);
    check("multi_60.out_lit", 32'(r_out), 32'd6);
    check("multi_60.grant_lit", 32'(r_grant), 32'h40);
    step("all_ff", 8'hFF);
    check("all_ff.grant_lit", 32'(r_grant), 32'h80);
    step("pre_zero", 8'h80);
    step("zero", 8'h00);
    step("one", 8'h01);
    check("one.valid_lit", 32'(r_valid), 32'd1);

    // Back-to-back alternation
    for (int i = 0; i < 10; i++) step("alt", (i % 2 == 0) ? 8'h01 : 8'h80);

    // Asynchronous reset in the middle of a run, with in=8'h80
    step("pre_rst", 8'h80);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release.out", 32'(r_out), 32'd7);
    check("rst_release.valid", 32'(r_valid), 32'd1);
    check("rst_release.grant", 32'(r_grant), 32'h80);

    // Randomized run
    for (int i = 0; i < 200; i++) begin
      logic [7:0] v;
      v = (i % 16 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      step("rand", v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
